sync_fifo: RTL and testbench

Parametrised multi-entry valid/ready FIFO; successor to the single-entry skid buffer in the interconnect layer. Decouples spike/event producers from the LIF neuron array and the arbiters. Sustains one push and one pop per cycle. Adds occupancy count, almost-full flag and a synchronous flush.

---
 rtl/sync_fifo_mem.sv | 35 +++
 rtl/sync_fifo.sv | 102 ++++++++++
 tb/tb_sync_fifo.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: DEPTH x WIDTH registers, one synchronous write
// port and one asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk       rising-edge clock
//   wr_en     write strobe; wr_data lands in mem[wr_addr] at the edge
//   wr_addr   write address, 0..DEPTH-1
//   wr_data   write payload
//   rd_addr   read address, 0..DEPTH-1
//   rd_data_c combinational read of mem[rd_addr]
module sync_fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; storage deliberately has no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read of the addressed entry.
  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Parametrised valid/ready FIFO with occupancy count, almost-full flag and a
// synchronous flush. One push and one pop per cycle; no fall-through.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   flush        synchronous clear; discards any same-cycle push/pop
//   in_valid     producer has data
//   in_data      producer payload
//   in_ready     FIFO can accept (not full)
//   out_valid    head entry valid (not empty)
//   out_data     head entry payload
//   out_ready    consumer accepts head
//   count        stored entries, 0..DEPTH
//   almost_full  count >= AF_LEVEL
module sync_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_d;
  logic          push_c, pop_c;

  // Handshakes use only registered flags, so no combinational in->out paths.
  assign push_c = in_valid & in_ready;
  assign pop_c  = out_valid & out_ready;

  // Next-state: flush wins; pointers wrap by explicit compare for any DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
      end
      if (push_c && !pop_c) begin
        count_d = count + CW'(1);
      end else if (pop_c && !push_c) begin
        count_d = count - CW'(1);
      end
    end
  end

  // State and flags; flags are pre-decoded from the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count       <= count_d;
      in_ready    <= (count_d != CNT_FULL);
      out_valid   <= (count_d != '0);
      almost_full <= (count_d >= CNT_AF);
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en     (push_c & ~flush),
    .wr_addr   (wr_ptr_q),
    .wr_data   (in_data),
    .rd_addr   (rd_ptr_q),
    .rd_data_c (out_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  typedef logic [7:0] q_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready4, out_valid4, af4;
  logic [7:0] out_data4;
  logic [2:0] count4;
  logic       in_ready3, out_valid3, af3;
  logic [7:0] out_data3;
  logic [1:0] count3;

  int tests = 0;
  int fails = 0;
  q_t q4, q3;

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready),
    .count(count4), .almost_full(af4)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready),
    .count(count3), .almost_full(af3)
  );

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from the model queue contents.
  task automatic chk_dut(input string name, input q_t q, input int depth, input int af_level,
                         input logic ir, input logic ov, input int unsigned cnt,
                         input logic af, input logic [7:0] od);
    chk({name, ".count"}, cnt, q.size());
    chk({name, ".in_ready"}, 32'(ir), 32'(q.size() < depth));
    chk({name, ".out_valid"}, 32'(ov), 32'(q.size() > 0));
    chk({name, ".almost_full"}, 32'(af), 32'(q.size() >= af_level));
    if (q.size() > 0) chk({name, ".out_data"}, 32'(od), 32'(q[0]));
  endtask

  task automatic chk_all();
    chk_dut("d4", q4, 4, 3, in_ready4, out_valid4, 32'(count4), af4, out_data4);
    chk_dut("d3", q3, 3, 2, in_ready3, out_valid3, 32'(count3), af3, out_data3);
  endtask

  // Reference FIFO: flush empties; push accepted only if not full before the edge.
  task automatic upd(input q_t qi, input int depth, output q_t qo);
    bit pu, po;
    qo = qi;
    if (flush) begin
      qo.delete();
    end else begin
      pu = in_valid && (qi.size() < depth);
      po = out_ready && (qi.size() > 0);
      if (po) void'(qo.pop_front());
      if (pu) qo.push_back(in_data);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
    @(negedge clk);
    chk_all();
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    upd(q4, 4, q4);
    upd(q3, 3, q3);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full, refused fifth push, then full push+pop pops only.
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    step(1, 8'h44, 0, 0);
    step(1, 8'h55, 0, 0);
    step(1, 8'h55, 1, 0);
    step(1, 8'h55, 0, 0);
    repeat (6) step(0, 8'h00, 1, 0);

    // Continuous stream with both sides ready; exercises pointer wrap.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 1, 0);
    repeat (5) step(0, 8'h00, 1, 0);

    // Flush with a same-cycle push; that payload must vanish.
    step(1, 8'hAA, 0, 0);
    step(1, 8'hBB, 0, 0);
    step(1, 8'hCC, 0, 1);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));

    // Build occupancy then assert reset between edges.
    repeat (3) step(1, 8'($urandom), 0, 0);
    @(negedge clk);
    chk_all();
    #2 rst_n = 1'b0;
    #1;
    q4.delete();
    q3.delete();
    chk_all();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    @(negedge clk);
    chk_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
